// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : pc_sequencer
// Brief   : Fetch/execute program-counter sequencer with memory handshake,
//           jump load, wrap-around PC and a terminal HALT instruction.
// Revision: 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int                ADDR_W       = 11,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              pre_load,
  input  logic [15:0]       mem_data,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] PC,
  output logic [15:0]       IR,
  output logic              ir_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [4:0]        HALT_OPCODE = 5'b11111;
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;

  // Async reset clears the state flop, so mem_req drops without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_VECTOR;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (ir_q[15:11] == HALT_OPCODE) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pre_load ? ir_q[ADDR_W-1:0] : pc_q + PC_STEP;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_req  = (state_q == S_FETCH);
  assign ir_valid = (state_q == S_EXEC);
  assign halted   = (state_q == S_HALT);
  assign PC       = pc_q;
  assign IR       = ir_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_sequencer
// Brief   : Directed self-checking bench for pc_sequencer with a cycle model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int          ADDR_W = 11;
  localparam logic [10:0] RV     = 11'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        pre_load;
  logic [15:0] mem_data;
  logic        mem_ack;
  wire         mem_req;
  wire  [10:0] PC;
  wire  [15:0] IR;
  wire         ir_valid;
  wire         halted;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .run(run), .pre_load(pre_load),
    .mem_data(mem_data), .mem_ack(mem_ack), .mem_req(mem_req),
    .PC(PC), .IR(IR), .ir_valid(ir_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  // Behavioural reference: what phase the sequencer is in, and its PC/IR.
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;
  int          m_mode;
  logic [10:0] m_pc;
  logic [15:0] m_ir;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode <= M_IDLE;
      m_pc   <= RV;
      m_ir   <= 16'h0000;
    end else begin
      if (m_mode == M_IDLE) begin
        if (run) m_mode <= M_FETCH;
      end else if (m_mode == M_FETCH) begin
        if (mem_ack) begin
          m_ir   <= mem_data;
          m_mode <= M_EXEC;
        end
      end else if (m_mode == M_EXEC) begin
        if (m_ir[15:11] == 5'd31) begin
          m_mode <= M_HALT;
        end else begin
          m_pc   <= pre_load ? m_ir[10:0] : 11'((int'(m_pc) + 1) % 2048);
          m_mode <= run ? M_FETCH : M_IDLE;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({PC, IR, mem_req, ir_valid, halted} !==
          {m_pc, m_ir, (m_mode == M_FETCH), (m_mode == M_EXEC), (m_mode == M_HALT)}) begin
        errors++;
        $display("FAIL model t=%0t got PC=%h IR=%h req=%b iv=%b h=%b want PC=%h IR=%h mode=%0d",
                 $time, PC, IR, mem_req, ir_valid, halted, m_pc, m_ir, m_mode);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts in FETCH; waits 'dly' cycles without ack, then completes EXEC.
  task automatic fetch_one(input logic [15:0] data, input int dly, input logic pl,
                           output int req_cycles);
    req_cycles = 0;
    pre_load   = ~pl;
    for (int i = 0; i < dly; i++) begin
      if (mem_req) req_cycles++;
      mem_ack  = 1'b0;
      mem_data = 16'hDEAD;
      tick();
    end
    if (mem_req) req_cycles++;
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    mem_data = 16'hBEEF;
    check("exec_iv", {31'd0, ir_valid}, 32'd1);
    check("exec_req", {31'd0, mem_req}, 32'd0);
    check("exec_ir", {16'd0, IR}, {16'd0, data});
    pre_load = pl;
    tick();
    pre_load = 1'b0;
  endtask

  int rc;

  initial begin
    reset = 1'b1; run = 1'b0; pre_load = 1'b0; mem_data = 16'h0; mem_ack = 1'b0;
    tick();
    check("rst_pc", {21'd0, PC}, {21'd0, RV});
    check("rst_ir", {16'd0, IR}, 32'h0);
    check("rst_flags", {29'd0, mem_req, ir_valid, halted}, 32'd0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    tick();
    check("idle_hold", {31'd0, mem_req}, 32'd0);

    // Sequential run: PC 0,1,2,3 with immediate ack.
    run = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("seq_req", {31'd0, mem_req}, 32'd1);
      check("seq_pc", {21'd0, PC}, k);
      fetch_one(16'h0100 + 16'(k), 0, 1'b0, rc);
    end

    // Jump from PC=5 via IR=0x2123.
    fetch_one(16'h0000, 0, 1'b0, rc);
    check("jmp_pre_pc", {21'd0, PC}, 32'd5);
    fetch_one(16'h2123, 0, 1'b1, rc);
    check("jmp_pc", {21'd0, PC}, 32'h123);
    check("jmp_req", {31'd0, mem_req}, 32'd1);

    // Wrap at 2047 with a 3-cycle ack delay.
    fetch_one(16'h07FF, 0, 1'b1, rc);
    check("wrap_pre_pc", {21'd0, PC}, 32'h7FF);
    fetch_one(16'h0123, 3, 1'b0, rc);
    check("wrap_req_cycles", rc, 32'd4);
    check("wrap_pc", {21'd0, PC}, 32'd0);

    // Run dropped mid-fetch: fetch and exec complete, then IDLE with PC+1.
    run = 1'b0;
    fetch_one(16'h0042, 1, 1'b0, rc);
    check("drop_pc", {21'd0, PC}, 32'd1);
    check("drop_idle", {29'd0, mem_req, ir_valid, halted}, 32'd0);
    mem_ack = 1'b1; pre_load = 1'b1; mem_data = 16'h0777;
    tick(); tick();
    check("idle_ignore_pc", {21'd0, PC}, 32'd1);
    check("idle_ignore_ir", {16'd0, IR}, 32'h0042);
    mem_ack = 1'b0; pre_load = 1'b0;

    // Reset during FETCH: immediate drop, late ack ignored.
    run = 1'b1;
    tick();
    check("abort_pre_req", {31'd0, mem_req}, 32'd1);
    run = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_pc", {21'd0, PC}, {21'd0, RV});
    mem_ack = 1'b1; mem_data = 16'h0555;
    tick();
    reset = 1'b0;
    tick(); tick();
    check("late_ack_ir", {16'd0, IR}, 32'h0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b0;
    run = 1'b1;
    tick();
    check("first_fetch_req", {31'd0, mem_req}, 32'd1);
    check("first_fetch_pc", {21'd0, PC}, {21'd0, RV});

    // Halt at PC=5 with pre_load asserted.
    fetch_one(16'h0005, 0, 1'b1, rc);
    check("halt_pre_pc", {21'd0, PC}, 32'd5);
    fetch_one(16'hF800, 0, 1'b1, rc);
    for (int i = 0; i < 4; i++) begin
      mem_ack  = i[0];
      pre_load = 1'b1;
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_pc", {21'd0, PC}, 32'd5);
      check("halt_req", {31'd0, mem_req}, 32'd0);
      tick();
    end
    mem_ack = 1'b0; pre_load = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("halt_exit", {31'd0, halted}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 11, giving the program counter width in bits.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset; clk and reset are named as in the codebase.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  level; 1 = sequencer may start and continue fetches.
REQ-007 pre_load  input  1  jump-taken decision from the jump block, sampled in EXEC only.
REQ-008 mem_data  input  16  instruction word from program memory, valid when mem_ack=1.
REQ-009 mem_ack  input  1  memory response strobe, one or more cycles after mem_req.
REQ-010 mem_req  output  1  fetch request; held high until mem_ack.
REQ-011 PC  output  ADDR_W  current program counter, also the fetch address.
REQ-012 IR  output  16  instruction register, bits B15..B0.
REQ-013 ir_valid  output  1  high for exactly the EXEC cycle.
REQ-014 halted  output  1  high while in HALT state.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, EXEC and HALT.
REQ-016 In IDLE, the FSM SHALL stay while run=0 and SHALL go to FETCH on the next edge when run=1.
REQ-017 In FETCH, mem_req SHALL be 1 and PC SHALL be held stable.
REQ-018 In FETCH with mem_ack=1, IR SHALL capture mem_data and the FSM SHALL go to EXEC on the same edge.
REQ-019 In FETCH with mem_ack=0, the FSM SHALL remain in FETCH, with no timeout.
REQ-020 In EXEC, ir_valid SHALL be 1, mem_req SHALL be 0 and IR SHALL be stable, so the jump block can decode it.
REQ-021 On leaving EXEC, PC SHALL become IR[ADDR_W-1:0] if pre_load=1, else PC+1 modulo 2^ADDR_W.
REQ-022 PC SHALL wrap from 2^ADDR_W-1 to 0 with no flag or stall.
REQ-023 If IR[15:11]=5'b11111 in EXEC, the FSM SHALL go to HALT, PC SHALL remain unchanged and pre_load SHALL be ignored.
REQ-024 Otherwise, from EXEC the FSM SHALL go to FETCH if run=1 and to IDLE if run=0.
REQ-025 run falling while in FETCH SHALL NOT abort the fetch; the FSM SHALL complete FETCH and EXEC, then go to IDLE.
REQ-026 In HALT, halted SHALL be 1 and mem_req SHALL be 0.
REQ-027 HALT SHALL be left only by reset.
REQ-028 pre_load SHALL be ignored in all states except EXEC.
REQ-029 mem_ack SHALL be ignored in all states except FETCH.
REQ-030 A fetch SHALL take a minimum of 2 cycles (FETCH with immediate ack, then EXEC).

Reset
REQ-031 While reset=1, outputs SHALL be: PC=RESET_VECTOR, IR=16'h0000, mem_req=0, ir_valid=0, halted=0, and the state SHALL be IDLE.
REQ-032 Reset asserted mid-FETCH SHALL drop mem_req immediately, without waiting for a clock edge.
REQ-033 A mem_ack arriving after a mid-FETCH reset SHALL be ignored.
REQ-034 After reset is released, the first fetch SHALL use address RESET_VECTOR.

Verification
REQ-035 Sequential run: reset, run=1, mem_ack the cycle after each mem_req, pre_load=0 -> PC steps 0,1,2,3 and ir_valid pulses every 2nd cycle.
REQ-036 Jump: with PC=5, mem_data=16'h2123 and pre_load=1 in EXEC -> next fetch address is 11'h123 and mem_req is high.
REQ-037 Wrap and wait states: PC=2047, mem_ack delayed 3 cycles, pre_load=0 -> mem_req is high for 4 cycles and the next PC is 0.
REQ-038 Halt: mem_data=16'hF800 in EXEC with pre_load=1 -> halted=1, PC unchanged and mem_req=0 until reset.
REQ-039 Run drop and reset abort: run=0 during FETCH -> EXEC completes, then IDLE with PC advanced. Reset during FETCH -> mem_req=0 at once, PC=RESET_VECTOR, and a late mem_ack is ignored.
